// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with skid buffer, flush and a saturating stall counter.
// in_ready depends only on state and flush, so out_ready never reaches it combinationally.
//
// state | meaning
// EMPTY | nothing held, occupancy 0
// ONE   | main valid, occupancy 1
// FULL  | main and skid valid, occupancy 2, input blocked
module pipe_skid_reg #(
  parameter int PAYLOAD_W   = 71,
  parameter int CTRL_W      = 2,
  parameter int ZERO_BUBBLE = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAYLOAD_W-1:0]   out_payload,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;

  state_t                 state;
  state_t                 state_nxt;
  logic [PAYLOAD_W-1:0]   main_q;
  logic [PAYLOAD_W-1:0]   skid_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   in_fire;
  logic                   out_fire;
  logic                   load_main_in;
  logic                   load_main_skid;
  logic                   load_skid;

  assign in_ready  = (state != FULL) & ~flush;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_payload;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_payload;
    end
  end

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && !(&stall_q)) begin
      stall_q <= stall_q + STALL_ONE;
    end
  end

  assign stall_cnt = stall_q;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Control bits are gated explicitly so a bubble can never assert a write-back.
  logic [CTRL_W-1:0]           out_ctrl;
  logic [PAYLOAD_W-CTRL_W-1:0] out_data;

  generate
    if (ZERO_BUBBLE != 0) begin : g_zero_bubble
      assign out_ctrl = out_valid ? main_q[CTRL_W-1:0] : '0;
      assign out_data = out_valid ? main_q[PAYLOAD_W-1:CTRL_W] : '0;
    end else begin : g_hold
      assign out_ctrl = main_q[CTRL_W-1:0];
      assign out_data = main_q[PAYLOAD_W-1:CTRL_W];
    end
  endgenerate

  assign out_payload = {out_data, out_ctrl};

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have the parameter PAYLOAD_W, default 71, giving the bundled stage payload width (32 mem data + 32 ALU result + 5 rd + 2 control).
REQ-002 The block SHALL have the parameter CTRL_W, default 2, giving the number of payload LSBs treated as control bits (reg_write, mem_to_reg).
REQ-003 The block SHALL have the parameter ZERO_BUBBLE, default 1: 1 means out_payload reads 0 whenever out_valid=0; 0 means the last payload is held.
REQ-004 The block SHALL have the parameter STALL_CNT_W, default 16, giving the stall counter width.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the port in_valid, input, 1 bit: the upstream stage offers a payload.
REQ-008 The block SHALL have the port in_ready, output, 1 bit: the block accepts a payload this cycle.
REQ-009 The block SHALL have the port in_payload, input, PAYLOAD_W bits: the upstream payload.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: a payload is presented downstream.
REQ-011 The block SHALL have the port out_ready, input, 1 bit: the downstream stage accepts a payload this cycle.
REQ-012 The block SHALL have the port out_payload, output, PAYLOAD_W bits: the downstream payload.
REQ-013 The block SHALL have the port flush, input, 1 bit: a synchronous kill of all held entries.
REQ-014 The block SHALL have the port occupancy, output, 2 bits: the number of held entries (0..2).
REQ-015 The block SHALL have the port stall_cnt, output, STALL_CNT_W bits: a saturating count of back-pressured cycles.

Function
REQ-016 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-017 The block SHALL hold two registered entries, main and skid, and SHALL implement a 3-state FSM: EMPTY (occupancy 0), ONE (main valid, occupancy 1) and FULL (main and skid valid, occupancy 2).
REQ-018 The block SHALL drive in_ready = (state != FULL) & ~flush, combinationally from state and flush only, with no path from out_ready.
REQ-019 The block SHALL drive out_valid = (state != EMPTY), and out_payload SHALL always come from main.
REQ-020 In EMPTY, in_fire SHALL move the FSM to ONE with main <= in_payload.
REQ-021 In ONE with in_fire & out_fire, the FSM SHALL stay in ONE with main <= in_payload (full-throughput pass-through, 1-cycle latency).
REQ-022 In ONE with in_fire & ~out_fire, the FSM SHALL move to FULL with skid <= in_payload and main unchanged.
REQ-023 In ONE with ~in_fire & out_fire, the FSM SHALL move to EMPTY.
REQ-024 In FULL, out_fire SHALL move the FSM to ONE with main <= skid; no input is accepted in FULL.
REQ-025 Payloads SHALL leave in acceptance order; none is dropped or duplicated absent flush.
REQ-026 flush=1 SHALL force the next state to EMPTY from any state; a simultaneous out_fire completes this cycle, but no in_fire occurs because in_ready=0.
REQ-027 When out_valid=0 and ZERO_BUBBLE=1, out_payload SHALL be all zeros, so the low CTRL_W control bits are 0 and a bubble never writes back.
REQ-028 When out_valid=0 and ZERO_BUBBLE=0, out_payload SHALL retain main.
REQ-029 stall_cnt SHALL increment by 1 on each cycle with out_valid & ~out_ready, SHALL saturate at all-ones, and SHALL NOT be cleared by flush.

Reset
REQ-030 Asserting reset SHALL immediately, without a clock edge, force: state EMPTY, main = 0, skid = 0, stall_cnt = 0.
REQ-031 While reset is asserted, outputs SHALL read out_valid=0, occupancy=0, out_payload=0 and in_ready=~flush.
REQ-032 Reset asserted mid-transfer SHALL discard held entries, and the first edge after deassertion SHALL behave as from EMPTY.

Verification
REQ-033 Pass-through: out_ready=1, in_valid=1 with payloads (mem 0xABCD1234, alu 0xDEADBEEF, rd 10, ctrl 2'b11) then (0xCAFEBABE, 0x12345678, 5, 2'b10) on consecutive cycles -> each appears on out_payload one cycle later; occupancy stays 1; stall_cnt=0.
REQ-034 Back-pressure: out_ready=0, offer A then B -> occupancy reaches 2, in_ready=0, out_payload=A; raise out_ready -> A then B emitted in order; stall_cnt equals the stalled cycle count.
REQ-035 Flush in FULL: hold A and B, assert flush for 1 cycle -> next cycle occupancy=0, out_valid=0, out_payload=0 (ZERO_BUBBLE=1), and neither A nor B ever emitted.
REQ-036 Async reset mid-operation: reset pulsed between clock edges in state FULL -> outputs zero before the next edge; the subsequent payload passes with 1-cycle latency.
REQ-037 Saturation: STALL_CNT_W=4 with out_ready=0 for 20 cycles while out_valid=1 -> stall_cnt stops at 15.
REQ-038 ZERO_BUBBLE=0: pass one payload then drain -> out_valid=0 while out_payload still holds the last value.
